// File: rtl/bit_serializer.sv
// Purpose : parallel-to-serial front end, WIDTH-bit words shifted out MSB-first,
//           one bit per clock, optional trailing odd-parity bit.
// Latency : word accepted at edge N -> MSB on serial_out in cycle N+1;
//           WIDTH cycles per word (WIDTH+1 with parity), no gap back-to-back.
// Backpressure: in_ready is high only in IDLE and in the final bit cycle of a
//           word; in_valid while in_ready=0 is ignored and must be held.
//
// Ports:
//   clk, rst        single clock, synchronous active-high reset
//   in_data/in_valid/in_ready  word input handshake (accept = valid && ready)
//   serial_out      registered serial bit (feeds the downstream 101 checker)
//   bit_valid       registered, serial_out carries a data or parity bit
//   word_done       registered one-cycle pulse on the final bit of a word
//
// Optional feature: define BIT_SERIALIZER_PARITY_EN to append an odd-parity
// bit after every word (adds the PARITY state).

module bit_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             serial_out,
  output logic             bit_valid,
  output logic             word_done
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             serial_out_q, serial_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             word_done_q, word_done_d;
  logic             accept;
`ifdef BIT_SERIALIZER_PARITY_EN
  // Running XOR of the data bits already sent for the current word.
  logic             par_q, par_d;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      serial_out_q <= 1'b0;
      bit_valid_q  <= 1'b0;
      word_done_q  <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      serial_out_q <= serial_out_d;
      bit_valid_q  <= bit_valid_d;
      word_done_q  <= word_done_d;
`ifdef BIT_SERIALIZER_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake: in_ready depends on the current state only, so it never
  // depends on in_valid and the accept path has no combinational loop.
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      IDLE:   in_ready = 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
      SHIFT:  in_ready = 1'b0;
      PARITY: in_ready = 1'b1;
`else
      // Without parity the last data bit is the acceptance point, which is
      // what keeps back-to-back words gapless.
      SHIFT:  in_ready = (cnt_q == '0);
`endif
      default: in_ready = 1'b0;
    endcase
  end

  assign accept = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
`ifdef BIT_SERIALIZER_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          shreg_d = in_data;
          cnt_d   = CNT_LAST;
`ifdef BIT_SERIALIZER_PARITY_EN
          par_d   = 1'b0;
`endif
        end
      end

      SHIFT: begin
`ifdef BIT_SERIALIZER_PARITY_EN
        par_d = par_q ^ shreg_q[WIDTH-1];
`endif
        if (cnt_q != '0) begin
          shreg_d = shreg_q << 1;
          cnt_d   = cnt_q - CNT_ONE;
        end else begin
`ifdef BIT_SERIALIZER_PARITY_EN
          state_d = PARITY;
`else
          if (accept) begin
            state_d = SHIFT;
            shreg_d = in_data;
            cnt_d   = CNT_LAST;
          end else begin
            state_d = IDLE;
          end
`endif
        end
      end

`ifdef BIT_SERIALIZER_PARITY_EN
      PARITY: begin
        if (accept) begin
          state_d = SHIFT;
          shreg_d = in_data;
          cnt_d   = CNT_LAST;
          par_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: the serial outputs are registered, so their next values are
  // decoded from the next state; the flops then show the bit that belongs to
  // the state being entered.
  // ---------------------------------------------------------------------------
  always_comb begin
    serial_out_d = 1'b0;
    bit_valid_d  = 1'b0;
    word_done_d  = 1'b0;
    case (state_d)
      SHIFT: begin
        serial_out_d = shreg_d[WIDTH-1];
        bit_valid_d  = 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
        word_done_d  = 1'b0;
`else
        word_done_d  = (cnt_d == '0);
`endif
      end
`ifdef BIT_SERIALIZER_PARITY_EN
      PARITY: begin
        // par_d is the XOR of all WIDTH data bits here; inverting it makes
        // the total count of ones across data + parity odd.
        serial_out_d = ~par_d;
        bit_valid_d  = 1'b1;
        word_done_d  = 1'b1;
      end
`endif
      default: begin
        serial_out_d = 1'b0;
        bit_valid_d  = 1'b0;
        word_done_d  = 1'b0;
      end
    endcase
  end

  assign serial_out = serial_out_q;
  assign bit_valid  = bit_valid_q;
  assign word_done  = word_done_q;

endmodule
